// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the IF stage: word/address types, bubble encoding,
// IF FSM state encoding and the PC increment helper.
package instruction_fetch_stage_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Encoding loaded into IF/ID for every bubble
    localparam word_t NOP_INSTR_DEF = 16'h0800;

    typedef enum logic {
        IF_BOOT = 1'b0,
        IF_RUN  = 1'b1
    } if_state_e;

    // Modulo-2^16 increment; FFFF wraps to 0000 silently
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Bus bundle between the IF stage and its surroundings: hazard/redirect
// controls, instruction memory port and the IF/ID register outputs.
interface instruction_fetch_stage_if;
    import instruction_fetch_stage_pkg::*;

    logic  stall_i;
    logic  redirect_i;
    addr_t redirect_pc_i;
    logic  mem_conflict_i;
    addr_t imem_addr_o;
    word_t imem_instr_i;
    word_t ifid_instr_o;
    addr_t ifid_pc1_o;
    logic  ifid_valid_o;

    // Environment side: hazard unit, branch unit, instruction memory, ID stage
    modport master (
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        output mem_conflict_i,
        input  imem_addr_o,
        output imem_instr_i,
        input  ifid_instr_o,
        input  ifid_pc1_o,
        input  ifid_valid_o
    );

    // Fetch stage side
    modport slave (
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  mem_conflict_i,
        output imem_addr_o,
        input  imem_instr_i,
        output ifid_instr_o,
        output ifid_pc1_o,
        output ifid_valid_o
    );

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: bubble (NOP, invalid) has priority over load;
// with neither asserted all three fields hold.
module instruction_fetch_stage_if_id_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  load_i,
    input  logic  bubble_i,
    input  word_t instr_i,
    input  addr_t pc1_i,
    output word_t instr_o,
    output addr_t pc1_o,
    output logic  valid_o
);

    word_t instr_q;
    addr_t pc1_q;
    logic  valid_q;

    // Reset and bubble both leave a NOP with PC+1 cleared
    always_ff @(posedge CLK) begin
        if (RST || bubble_i) begin
            instr_q <= NOP_INSTR;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc1_q   <= pc1_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc1_o   = pc1_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage of the 16-bit pipelined CPU: PC, next-PC selection, post-reset
// boot wait FSM and the IF/ID register.
// Optional feature macro: IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
`ifdef IF_PERF_CNT_EN
    parameter int unsigned PERF_W      = 32,
`endif
    parameter addr_t       RESET_PC    = 16'h0000,
    parameter word_t       NOP_INSTR   = NOP_INSTR_DEF,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
`ifdef IF_PERF_CNT_EN
    output logic [PERF_W-1:0]     perf_fetch_o,
    output logic [PERF_W-1:0]     perf_bubble_o,
`endif
    instruction_fetch_stage_if.slave bus
);

    localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

    if_state_e  state_q, state_d;
    logic [3:0] boot_cnt_q, boot_cnt_d;
    addr_t      pc_q, pc_d;
    logic       ifid_load;
    logic       ifid_bubble;

    // State register: FSM state, boot counter and PC
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IF_BOOT;
            boot_cnt_q <= '0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
        end
    end

    // Next state: leave BOOT after BOOT_CYCLES edges, RUN is terminal
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        unique case (state_q)
            IF_BOOT: begin
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BootLast) begin
                    state_d = IF_RUN;
                end
            end
            IF_RUN: state_d = IF_RUN;
        endcase
    end

    // Outputs: next PC and IF/ID control; redirect beats stall because the
    // stalled ID instruction is on the wrong path
    always_comb begin
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            IF_BOOT: ifid_bubble = 1'b1;
            IF_RUN: begin
                if (bus.redirect_i) begin
                    pc_d        = bus.redirect_pc_i;
                    ifid_bubble = 1'b1;
                end else if (bus.stall_i) begin
                    pc_d = pc_q;
                end else if (bus.mem_conflict_i) begin
                    // PC held so the same address is refetched next cycle
                    ifid_bubble = 1'b1;
                end else begin
                    pc_d      = pc_inc(pc_q);
                    ifid_load = 1'b1;
                end
            end
        endcase
    end

    assign bus.imem_addr_o = pc_q;

    instruction_fetch_stage_if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_register (
        .CLK      (CLK),
        .RST      (RST),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (bus.imem_instr_i),
        .pc1_i    (pc_inc(pc_q)),
        .instr_o  (bus.ifid_instr_o),
        .pc1_o    (bus.ifid_pc1_o),
        .valid_o  (bus.ifid_valid_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [PERF_W-1:0] perf_fetch_q;
    logic [PERF_W-1:0] perf_bubble_q;

    // Saturating counters; stall cycles count in neither
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (ifid_load && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 1'b1;
            end
            if (ifid_bubble && (perf_bubble_q != '1)) begin
                perf_bubble_q <= perf_bubble_q + 1'b1;
            end
        end
    end

    assign perf_fetch_o  = perf_fetch_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed hazard scenarios
// followed by randomized hazards/resets, checked against a behavioural model.
module tb_instruction_fetch_stage;
    import instruction_fetch_stage_pkg::*;

    localparam int unsigned BOOT = 2;
    localparam int unsigned PW   = 32;
    localparam word_t       NOP  = 16'h0800;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_stage_if bus ();

`ifdef IF_PERF_CNT_EN
    logic [PW-1:0] perf_fetch;
    logic [PW-1:0] perf_bubble;
`endif

    instruction_fetch_stage #(
`ifdef IF_PERF_CNT_EN
        .PERF_W      (PW),
`endif
        .RESET_PC    (16'h0000),
        .NOP_INSTR   (NOP),
        .BOOT_CYCLES (BOOT)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_o  (perf_fetch),
        .perf_bubble_o (perf_bubble),
`endif
        .bus           (bus)
    );

    // Instruction memory contents as a fixed scramble of the address
    function automatic word_t mem_word(input addr_t a);
        logic [31:0] p;
        p = {16'h0, a} * 32'h0000_9E37;
        return p[15:0] ^ 16'h3C5A;
    endfunction

    assign bus.imem_instr_i = mem_word(bus.imem_addr_o);

    typedef struct packed {
        word_t instr;
        addr_t pc1;
        logic  valid;
        logic  chk_pc1;
        addr_t pc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    addr_t  m_pc;
    int     m_boot_left;
    word_t  m_instr;
    addr_t  m_pc1;
    logic   m_valid;
    logic   m_chk;
    longint m_fetch;
    longint m_bubble;
    bit     started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_bubble_load();
        m_instr = NOP;
        m_valid = 1'b0;
        m_chk   = 1'b0;
        m_bubble++;
    endtask

    // Apply the rules of one rising edge to the model and queue the result
    task automatic model_step();
        if (rst) begin
            started     = 1'b1;
            m_pc        = 16'h0000;
            m_boot_left = BOOT;
            m_instr     = NOP;
            m_pc1       = 16'h0000;
            m_valid     = 1'b0;
            m_chk       = 1'b1;
            m_fetch     = 0;
            m_bubble    = 0;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
            m_bubble_load();
        end else if (bus.redirect_i) begin
            m_pc = bus.redirect_pc_i;
            m_bubble_load();
        end else if (bus.stall_i) begin
            // everything held
        end else if (bus.mem_conflict_i) begin
            m_bubble_load();
        end else begin
            m_instr = mem_word(m_pc);
            m_pc1   = m_pc + 16'd1;
            m_valid = 1'b1;
            m_chk   = 1'b1;
            m_pc    = m_pc + 16'd1;
            m_fetch++;
        end
        if (started) begin
            exp_q.push_back('{instr: m_instr, pc1: m_pc1, valid: m_valid, chk_pc1: m_chk,
                              pc: m_pc});
        end
    endtask

    // One clock: drive at negedge, model the rising edge, return at negedge
    task automatic cycle(input logic r, input logic s, input logic rd, input addr_t rpc,
                         input logic c);
        rst                = r;
        bus.stall_i        = s;
        bus.redirect_i     = rd;
        bus.redirect_pc_i  = rpc;
        bus.mem_conflict_i = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Monitor: compare IF/ID and fetch address shortly after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imem_addr", 32'(bus.imem_addr_o), 32'(e.pc));
            check("ifid_instr", 32'(bus.ifid_instr_o), 32'(e.instr));
            check("ifid_valid", 32'(bus.ifid_valid_o), 32'(e.valid));
            if (e.chk_pc1) begin
                check("ifid_pc1", 32'(bus.ifid_pc1_o), 32'(e.pc1));
            end
        end
    end

    initial begin
        rst                = 1'b1;
        bus.stall_i        = 1'b0;
        bus.redirect_i     = 1'b0;
        bus.redirect_pc_i  = '0;
        bus.mem_conflict_i = 1'b0;
        @(negedge clk);
        cycle(1, 0, 0, 16'h0, 0);
        cycle(1, 0, 0, 16'h0, 0);
        // boot wait, then straight-line fetch up to PC=0005
        for (int i = 0; i < BOOT + 5; i++) cycle(0, 0, 0, 16'h0, 0);
        // stall three cycles at PC=0005, then release
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 16'h0, 0);
        cycle(0, 0, 0, 16'h0, 0);
        // redirect beats stall
        cycle(0, 1, 1, 16'h0040, 0);
        cycle(0, 0, 0, 16'h0, 0);
        cycle(0, 0, 0, 16'h0, 0);
        // single-cycle data-port conflict at PC=0010
        cycle(0, 0, 1, 16'h0010, 0);
        cycle(0, 0, 0, 16'h0, 1);
        cycle(0, 0, 0, 16'h0, 0);
        cycle(0, 0, 0, 16'h0, 0);
        // wrap at FFFF
        cycle(0, 0, 1, 16'hFFFF, 0);
        cycle(0, 0, 0, 16'h0, 0);
        cycle(0, 0, 0, 16'h0, 0);
        cycle(0, 0, 0, 16'h0, 0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_directed", perf_fetch, 32'(m_fetch));
        check("perf_bubble_directed", perf_bubble, 32'(m_bubble));
`endif
        // randomized hazards with occasional mid-run resets
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 97) == 0, ($urandom % 4) == 0, ($urandom % 7) == 0,
                  16'($urandom), ($urandom % 5) == 0);
        end
        cycle(0, 0, 0, 16'h0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_final", perf_fetch, 32'(m_fetch));
        check("perf_bubble_final", perf_bubble, 32'(m_bubble));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
